// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared types and constants for the in-order pipeline control logic.
//   slot_t is one hazard-scoreboard entry. Its fields are sized for the
//   largest supported configuration (8-bit register numbers, 15 post-ID
//   stages). Narrower users zero-extend into it.
//   RDY_ALU / RDY_LOAD are the result-ready slots the decoder presents
//   for ALU and load instructions. BR_SLOT_DEF is the stage (MEM) in which
//   branches and jumps resolve.
package pipeline_pkg;

  localparam int REG_W_MAX   = 8;
  localparam int SLOT_W_MAX  = 4;
  localparam int BR_SLOT_DEF = 2;
  localparam int RDY_ALU     = 1;
  localparam int RDY_LOAD    = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_W_MAX-1:0]  rd;
    logic [SLOT_W_MAX-1:0] rdy_slot;
  } slot_t;

endpackage

// File: rtl/pipeline_hazard_unit_match.sv
// hazard_match
//   Combinational newest-match unit for one source operand. It finds the
//   youngest valid scoreboard slot (smallest k) that writes src_i. It then
//   decides whether to forward from that slot or to stall.
//   Optional feature macro: HAZARD_FWD_EN (full forwarding). When the macro
//   is undefined, any match stalls and sel_o stays 0.
// Ports
//   slots_i  scoreboard, slot 1 = EX ... slot DEPTH = WB
//   src_i    source register number (zero-extended)
//   used_i   the operand is actually read
//   stall_o  operand cannot be supplied this cycle
//   sel_o    0 = register file, k = forward from slot k
module hazard_match
  import pipeline_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int SLOT_W = 2
) (
  input  slot_t [DEPTH:1]       slots_i,
  input  logic [REG_W_MAX-1:0]  src_i,
  input  logic                  used_i,
  output logic                  stall_o,
  output logic [SLOT_W-1:0]     sel_o
);

  logic hit;
`ifdef HAZARD_FWD_EN
  logic [SLOT_W_MAX-1:0] k_hit;
  logic [SLOT_W_MAX-1:0] rdy_hit;
`endif

  always_comb begin
    hit     = 1'b0;
    stall_o = 1'b0;
    sel_o   = '0;
`ifdef HAZARD_FWD_EN
    k_hit   = '0;
    rdy_hit = '0;
`endif
    // Scan oldest to youngest so the last hit recorded is the newest writer.
    for (int k = DEPTH; k >= 1; k--) begin
      if (slots_i[k].valid && (slots_i[k].rd == src_i)) begin
        hit = 1'b1;
`ifdef HAZARD_FWD_EN
        k_hit   = SLOT_W_MAX'(k);
        rdy_hit = slots_i[k].rdy_slot;
`endif
      end
    end
    if (used_i && (src_i != '0) && hit) begin
`ifdef HAZARD_FWD_EN
      if (k_hit >= rdy_hit) sel_o = SLOT_W'(k_hit);
      else                  stall_o = 1'b1;
`else
      // Pure interlock: the value only reaches the register file on retire.
      stall_o = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard, interlock and forwarding controller for the in-order pipeline.
//   A shift-register scoreboard tracks every in-flight register writer,
//   with one slot per stage past ID. The PC/IF-ID keep, the ID/EX bubble,
//   the redirect flush and the operand forward selects are combinational
//   from the ID inputs and the registered scoreboard.
//   Optional feature macro: HAZARD_FWD_EN (forwarding). When it is
//   undefined, the unit is a pure interlock.
// Ports
//   clk, reset           clock, synchronous active-high reset
//   id_*                 instruction currently in ID
//   redirect             branch/jump in BR_SLOT redirects the PC
//   freeze               whole-pipeline hold; overrides everything
//   keep_pc              hold PC and IF/ID
//   bubble_idex          load a bubble into ID/EX
//   flush_ifid           clear IF/ID
//   fwd_sel_rs/rt        0 = register file, k = forward from slot k
//   stall_cnt            saturating count of hazard-stall cycles
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int  DEPTH   = 3,
  parameter int  REG_W   = 5,
  parameter int  BR_SLOT = BR_SLOT_DEF,
  parameter int  CNT_W   = 16,
  localparam int SLOT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_regwr,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [SLOT_W-1:0] id_rdy_slot,
  input  logic              redirect,
  input  logic              freeze,
  output logic              keep_pc,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic [SLOT_W-1:0] fwd_sel_rs,
  output logic [SLOT_W-1:0] fwd_sel_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t [DEPTH:1]  sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs, stall_rt, hazard;

  hazard_match #(.DEPTH(DEPTH), .SLOT_W(SLOT_W)) u_match_rs (
    .slots_i (sb_q),
    .src_i   (REG_W_MAX'(id_rs)),
    .used_i  (id_rs_used),
    .stall_o (stall_rs),
    .sel_o   (fwd_sel_rs)
  );

  hazard_match #(.DEPTH(DEPTH), .SLOT_W(SLOT_W)) u_match_rt (
    .slots_i (sb_q),
    .src_i   (REG_W_MAX'(id_rt)),
    .used_i  (id_rt_used),
    .stall_o (stall_rt),
    .sel_o   (fwd_sel_rt)
  );

  assign hazard    = id_valid & (stall_rs | stall_rt);
  assign stall_cnt = cnt_q;

  // Priority: freeze > redirect > hazard.
  always_comb begin
    keep_pc     = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    if (freeze) begin
      keep_pc = 1'b1;
    end else if (redirect) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (hazard) begin
      keep_pc     = 1'b1;
      bubble_idex = 1'b1;
    end
  end

  always_comb begin
    sb_d  = sb_q;
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_d[k] = sb_q[k-1];
        // Slots before the branch hold younger, wrong-path instructions.
        if (redirect && ((k - 1) < BR_SLOT)) sb_d[k].valid = 1'b0;
      end
      sb_d[1].valid    = id_valid & id_regwr & (id_rd != '0) & ~hazard & ~redirect;
      sb_d[1].rd       = REG_W_MAX'(id_rd);
      sb_d[1].rdy_slot = SLOT_W_MAX'(id_rdy_slot);
      if (hazard && !redirect && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

  localparam int DEPTH  = 3;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;
  localparam int SLOT_W = 2;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid, id_rs_used, id_rt_used, id_regwr;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic [SLOT_W-1:0] id_rdy_slot;
  logic              redirect, freeze;
  logic              keep_pc, bubble_idex, flush_ifid;
  logic [SLOT_W-1:0] fwd_sel_rs, fwd_sel_rt;
  logic [CNT_W-1:0]  stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.DEPTH(DEPTH), .REG_W(REG_W), .BR_SLOT(2), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_regwr    (id_regwr),
    .id_rd       (id_rd),
    .id_rdy_slot (id_rdy_slot),
    .redirect    (redirect),
    .freeze      (freeze),
    .keep_pc     (keep_pc),
    .bubble_idex (bubble_idex),
    .flush_ifid  (flush_ifid),
    .fwd_sel_rs  (fwd_sel_rs),
    .fwd_sel_rt  (fwd_sel_rt),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input bit k, input bit b, input bit f);
    chk({tag, ".keep_pc"}, 32'(keep_pc), 32'(k));
    chk({tag, ".bubble"}, 32'(bubble_idex), 32'(b));
    chk({tag, ".flush"}, 32'(flush_ifid), 32'(f));
  endtask

  task automatic set_in(input bit v, input logic [4:0] rs, input bit rsu,
                        input logic [4:0] rt, input bit rtu, input bit wr,
                        input logic [4:0] rd, input logic [1:0] rdy);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_regwr = wr; id_rd = rd; id_rdy_slot = rdy; redirect = 1'b0; freeze = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #3;
    chk_ctl("reset", 0, 0, 0);
    chk("reset.sel_rs", 32'(fwd_sel_rs), 0);
    chk("reset.sel_rt", 32'(fwd_sel_rt), 0);
    chk("reset.cnt", 32'(stall_cnt), 0);
    tick();

    // ALU -> dependent ALU
    set_in(1, 0, 0, 0, 0, 1, 3, 1); #3 chk_ctl("s1_add", 0, 0, 0); tick();
    set_in(1, 3, 1, 1, 1, 1, 4, 1); #3
    chk_ctl("s1_sub", !FWD, !FWD, 0);
    chk("s1_sub.sel_rs", 32'(fwd_sel_rs), FWD ? 1 : 0);
    chk("s1_sub.sel_rt", 32'(fwd_sel_rt), 0);
    exp_cnt += FWD ? 0 : 1;
    tick();
    idle(3);
    chk("s1.cnt", 32'(stall_cnt), 32'(exp_cnt));

    // load-use
    set_in(1, 0, 0, 0, 0, 1, 5, 2); #3 chk_ctl("s2_lw", 0, 0, 0); tick();
    set_in(1, 5, 1, 5, 1, 1, 6, 1); #3
    chk_ctl("s2_use1", 1, 1, 0);
    chk("s2_use1.sel_rs", 32'(fwd_sel_rs), 0);
    exp_cnt++;
    tick(); #3
`ifdef HAZARD_FWD_EN
    chk_ctl("s2_use2", 0, 0, 0);
    chk("s2_use2.sel_rs", 32'(fwd_sel_rs), 2);
    chk("s2_use2.sel_rt", 32'(fwd_sel_rt), 2);
    tick();
`else
    chk_ctl("s2_use2", 1, 1, 0); exp_cnt++; tick(); #3
    chk_ctl("s2_use3", 1, 1, 0); exp_cnt++; tick(); #3
    chk_ctl("s2_use4", 0, 0, 0);
    chk("s2_use4.sel_rs", 32'(fwd_sel_rs), 0);
    tick();
`endif
    chk("s2.cnt", 32'(stall_cnt), 32'(exp_cnt));
    idle(3);

    // writes to r0 are never tracked
    set_in(1, 0, 0, 0, 0, 1, 0, 1); #3 chk_ctl("s3_wr0", 0, 0, 0); tick();
    set_in(1, 0, 1, 0, 1, 0, 0, 1); #3
    chk_ctl("s3_use0", 0, 0, 0);
    chk("s3.sel_rs", 32'(fwd_sel_rs), 0);
    chk("s3.sel_rt", 32'(fwd_sel_rt), 0);
    tick();
    idle(1);

    // two writers of r7 in slots 1 and 3, r8 in slot 2
    set_in(1, 0, 0, 0, 0, 1, 7, 1); tick();
    set_in(1, 0, 0, 0, 0, 1, 8, 1); tick();
    set_in(1, 0, 0, 0, 0, 1, 7, 1); tick();
    set_in(1, 7, 1, 8, 1, 0, 0, 1); #3
    chk_ctl("s4_use", !FWD, !FWD, 0);
    chk("s4.sel_rs", 32'(fwd_sel_rs), FWD ? 1 : 0);
    chk("s4.sel_rt", 32'(fwd_sel_rt), FWD ? 2 : 0);
    exp_cnt += FWD ? 0 : 1;
    tick();
    idle(3);
    chk("s4.cnt", 32'(stall_cnt), 32'(exp_cnt));

    // redirect overriding a pending load-use hazard
    set_in(1, 0, 0, 0, 0, 1, 9, 2); tick();
    set_in(1, 9, 1, 0, 0, 1, 10, 1); redirect = 1'b1; #3
    chk_ctl("s5_redir", 0, 1, 1);
    tick();
    set_in(1, 9, 1, 10, 1, 0, 0, 1); #3
    chk_ctl("s5_after", 0, 0, 0);
    tick();
    chk("s5.cnt", 32'(stall_cnt), 32'(exp_cnt));
    idle(3);

    // freeze during a load-use stall
    set_in(1, 0, 0, 0, 0, 1, 5, 2); tick();
    set_in(1, 5, 1, 5, 1, 1, 6, 1); #3
    chk_ctl("s6_stall", 1, 1, 0);
    exp_cnt++;
    tick();
    for (int i = 0; i < 3; i++) begin
      freeze = 1'b1;
      redirect = (i == 1);
      #3
      chk_ctl("s6_frz", 1, 0, 0);
      chk("s6_frz.sel_rs", 32'(fwd_sel_rs), FWD ? 2 : 0);
      tick();
    end
    chk("s6_frz.cnt", 32'(stall_cnt), 32'(exp_cnt));
    freeze = 1'b0; redirect = 1'b0; #3
`ifdef HAZARD_FWD_EN
    chk_ctl("s6_rel", 0, 0, 0);
    chk("s6_rel.sel_rt", 32'(fwd_sel_rt), 2);
    tick();
`else
    chk_ctl("s6_rel1", 1, 1, 0); exp_cnt++; tick(); #3
    chk_ctl("s6_rel2", 1, 1, 0); exp_cnt++; tick(); #3
    chk_ctl("s6_rel3", 0, 0, 0);
    tick();
`endif
    chk("s6.cnt", 32'(stall_cnt), 32'(exp_cnt));
    idle(3);

    // reset asserted mid-stall
    set_in(1, 0, 0, 0, 0, 1, 5, 2); tick();
    set_in(1, 5, 1, 0, 0, 0, 0, 1); #3
    chk_ctl("s7_stall", 1, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    #3
    chk_ctl("s7_rel", 0, 0, 0);
    chk("s7.cnt", 32'(stall_cnt), 32'(exp_cnt));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
